hazard_ctrl: RTL and testbench

Central hazard/sequencing controller for the 5-stage pipeline. It drives write-enable and flush for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC write enable.
- Detects load-use hazards.
- Handles EX-stage-resolved taken branches and jumps.
- Sequences multi-cycle EX operations (mul/div) with a watchdog.
- Honours a global external freeze.

---
 rtl/hazard_ctrl.sv | 162 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: central hazard and sequencing controller for the 5-stage pipeline.
// Drives the pipeline-register write enables and flushes plus the PC write
// enable. Handles load-use bubbles, EX-resolved taken branches, multi-cycle
// EX operations with a watchdog, and a global external freeze.
// Optional feature: define PERF_CNT_EN to build the stall/flush perf counters;
// without it both counter outputs are tied to zero.
module hazard_ctrl #(
  parameter int MC_MAX_CYC = 32,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ext_stall,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mc_start,
  input  logic             mc_done,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_flush,
  output logic             exmem_we,
  output logic             exmem_flush,
  output logic             memwb_we,
  output logic             mc_busy,
  output logic             mc_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int MCW = $clog2(MC_MAX_CYC) + 1;

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] MC_WAIT = 1'b1;

  logic [0:0]     state;
  logic [0:0]     state_nxt;
  logic [MCW-1:0] mc_cnt;
  logic [MCW-1:0] mc_cnt_nxt;
  logic           timeout_nxt;
  logic           load_use;
  logic           mc_last;

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  assign mc_last = (mc_cnt == MCW'(MC_MAX_CYC - 1));

  assign mc_busy = rst && (state == MC_WAIT);

  // Prioritised control decode and next-state selection for the sequencer
  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    idex_we     = 1'b1;
    exmem_we    = 1'b1;
    memwb_we    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    state_nxt   = state;
    mc_cnt_nxt  = mc_cnt;
    timeout_nxt = 1'b0;

    if (!rst) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_we     = 1'b0;
      exmem_we    = 1'b0;
      memwb_we    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (ext_stall) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_we  = 1'b0;
      exmem_we = 1'b0;
      memwb_we = 1'b0;
    end else if (state == MC_WAIT) begin
      if (mc_done) begin
        state_nxt  = RUN;
        mc_cnt_nxt = '0;
      end else begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_we     = 1'b0;
        exmem_flush = 1'b1;
        if (mc_last) begin
          timeout_nxt = 1'b1;
          state_nxt   = RUN;
          mc_cnt_nxt  = '0;
        end else begin
          mc_cnt_nxt = mc_cnt + MCW'(1);
        end
      end
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (mc_start) begin
      if (!mc_done) begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_we     = 1'b0;
        exmem_flush = 1'b1;
        state_nxt   = MC_WAIT;
        mc_cnt_nxt  = MCW'(1);
      end
    end else if (load_use) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  // Sequencer state, wait counter and watchdog pulse register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= RUN;
      mc_cnt     <= '0;
      mc_timeout <= 1'b0;
    end else begin
      state      <= state_nxt;
      mc_cnt     <= mc_cnt_nxt;
      mc_timeout <= timeout_nxt;
    end
  end

`ifdef PERF_CNT_EN
  logic count_stall;
  logic count_flush;

  assign count_stall = !ext_stall && !pc_we;
  assign count_flush = !ext_stall && (state == RUN) && ex_branch_taken;

  // Saturating stall-cycle and branch-flush performance counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (count_stall && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (count_flush && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios plus randomized stimulus for hazard_ctrl,
// checked every cycle against a behavioural model of the pipeline rules.
// Counter expectations follow PERF_CNT_EN (zero when it is not defined).
module tb_hazard_ctrl;

  localparam int MAXC  = 6;
  localparam int CW    = 5;
  localparam int CMAX  = (1 << CW) - 1;
`ifdef PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic          clk;
  logic          rst;
  logic          ext_stall;
  logic [4:0]    id_rs1;
  logic [4:0]    id_rs2;
  logic          id_use_rs1;
  logic          id_use_rs2;
  logic [4:0]    ex_rd;
  logic          ex_mem_read;
  logic          ex_branch_taken;
  logic          mc_start;
  logic          mc_done;
  logic          pc_we;
  logic          ifid_we;
  logic          ifid_flush;
  logic          idex_we;
  logic          idex_flush;
  logic          exmem_we;
  logic          exmem_flush;
  logic          memwb_we;
  logic          mc_busy;
  logic          mc_timeout;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.MC_MAX_CYC(MAXC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ext_stall(ext_stall),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .mc_start(mc_start), .mc_done(mc_done),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .idex_we(idex_we), .idex_flush(idex_flush),
    .exmem_we(exmem_we), .exmem_flush(exmem_flush),
    .memwb_we(memwb_we), .mc_busy(mc_busy), .mc_timeout(mc_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: whether a multi-cycle op is outstanding, how many
  // cycles it has been waited on, the pending watchdog pulse, and event tallies
  bit modelValid = 1'b0;
  bit mWaiting;
  int mWaited;
  bit mTimeout;
  int mStalls;
  int mFlushes;

  bit ePc, eIfidWe, eIfidFl, eIdexWe, eIdexFl, eExmemWe, eExmemFl, eMemwbWe, eBusy;

  function automatic bit isLoadUse();
    if (!ex_mem_read || ex_rd == 5'd0) return 1'b0;
    return (id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd);
  endfunction

  task automatic calcExpected();
    bit allWe, multiStall, branch, bubble;
    allWe = rst && !ext_stall;
    multiStall = 1'b0; branch = 1'b0; bubble = 1'b0;
    if (allWe) begin
      if (mWaiting) multiStall = !mc_done;
      else if (ex_branch_taken) branch = 1'b1;
      else if (mc_start) multiStall = !mc_done;
      else bubble = isLoadUse();
    end
    ePc      = allWe && !multiStall && !bubble;
    eIfidWe  = allWe && !multiStall && !bubble;
    eIdexWe  = allWe && !multiStall;
    eExmemWe = allWe;
    eMemwbWe = allWe;
    eIfidFl  = !rst || branch;
    eIdexFl  = !rst || branch || bubble;
    eExmemFl = !rst || multiStall;
    eBusy    = rst && mWaiting;
  endtask

  // Model advance on each rising edge using the inputs of the ending cycle
  always @(posedge clk) begin
    if (!rst) begin
      modelValid = 1'b1;
      mWaiting = 1'b0; mWaited = 0; mTimeout = 1'b0; mStalls = 0; mFlushes = 0;
    end else if (modelValid) begin
      calcExpected();
      mTimeout = 1'b0;
      if (!ext_stall) begin
        if (!ePc && mStalls < CMAX) mStalls++;
        if (mWaiting) begin
          if (mc_done) begin
            mWaiting = 1'b0; mWaited = 0;
          end else if (mWaited + 1 >= MAXC) begin
            mTimeout = 1'b1; mWaiting = 1'b0; mWaited = 0;
          end else begin
            mWaited++;
          end
        end else if (ex_branch_taken) begin
          if (mFlushes < CMAX) mFlushes++;
        end else if (mc_start && !mc_done) begin
          mWaiting = 1'b1; mWaited = 1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  // Single compare process: every output against the model, mid-cycle
  always @(negedge clk) begin
    if (modelValid) begin
      calcExpected();
      checkOutput("pc_we",       int'(pc_we),       int'(ePc));
      checkOutput("ifid_we",     int'(ifid_we),     int'(eIfidWe));
      checkOutput("ifid_flush",  int'(ifid_flush),  int'(eIfidFl));
      checkOutput("idex_we",     int'(idex_we),     int'(eIdexWe));
      checkOutput("idex_flush",  int'(idex_flush),  int'(eIdexFl));
      checkOutput("exmem_we",    int'(exmem_we),    int'(eExmemWe));
      checkOutput("exmem_flush", int'(exmem_flush), int'(eExmemFl));
      checkOutput("memwb_we",    int'(memwb_we),    int'(eMemwbWe));
      checkOutput("mc_busy",     int'(mc_busy),     int'(eBusy));
      checkOutput("mc_timeout",  int'(mc_timeout),  int'(mTimeout));
      checkOutput("stall_cnt",   int'(stall_cnt),   PERF * mStalls);
      checkOutput("flush_cnt",   int'(flush_cnt),   PERF * mFlushes);
    end
  end

  task automatic applyStimulus(input bit r, input bit es, input int rs1, input int rs2,
                               input bit u1, input bit u2, input int rd, input bit mr,
                               input bit br, input bit st, input bit dn);
    rst = r; ext_stall = es;
    id_rs1 = 5'(rs1); id_rs2 = 5'(rs2);
    id_use_rs1 = u1; id_use_rs2 = u2;
    ex_rd = 5'(rd); ex_mem_read = mr;
    ex_branch_taken = br; mc_start = st; mc_done = dn;
  endtask

  task automatic idle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic midCycle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    nextCycle();
    midCycle();
    checkOutput("rst pc_we", int'(pc_we), 0);
    checkOutput("rst exmem_flush", int'(exmem_flush), 1);
    checkOutput("rst memwb_we", int'(memwb_we), 0);
    checkOutput("rst stall_cnt", int'(stall_cnt), 0);
    nextCycle(); idle();
    nextCycle();

    $display("[TB] load-use bubble");
    nextCycle(); applyStimulus(1, 0, 5, 0, 1, 0, 5, 1, 0, 0, 0);
    midCycle();
    checkOutput("lu pc_we", int'(pc_we), 0);
    checkOutput("lu ifid_we", int'(ifid_we), 0);
    checkOutput("lu idex_flush", int'(idex_flush), 1);
    nextCycle(); idle();
    midCycle();
    checkOutput("lu after pc_we", int'(pc_we), 1);
    checkOutput("lu stall_cnt", int'(stall_cnt), PERF * 1);

    $display("[TB] branch over load-use");
    nextCycle(); applyStimulus(1, 0, 5, 0, 1, 0, 5, 1, 1, 0, 0);
    midCycle();
    checkOutput("br pc_we", int'(pc_we), 1);
    checkOutput("br ifid_flush", int'(ifid_flush), 1);
    checkOutput("br idex_flush", int'(idex_flush), 1);
    nextCycle(); idle();
    midCycle();
    checkOutput("br stall_cnt", int'(stall_cnt), PERF * 1);
    checkOutput("br flush_cnt", int'(flush_cnt), PERF * 1);

    $display("[TB] multi-cycle op, done after 5 cycles");
    nextCycle(); applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    midCycle();
    checkOutput("mc entry exmem_flush", int'(exmem_flush), 1);
    for (int i = 0; i < 4; i++) begin
      nextCycle(); idle();
      midCycle();
      checkOutput("mc wait busy", int'(mc_busy), 1);
      checkOutput("mc wait pc_we", int'(pc_we), 0);
    end
    nextCycle(); applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    midCycle();
    checkOutput("mc done busy", int'(mc_busy), 1);
    checkOutput("mc done exmem_we", int'(exmem_we), 1);
    checkOutput("mc done exmem_flush", int'(exmem_flush), 0);
    nextCycle(); idle();
    midCycle();
    checkOutput("mc after busy", int'(mc_busy), 0);
    checkOutput("mc stall_cnt", int'(stall_cnt), PERF * 6);

    $display("[TB] watchdog");
    nextCycle(); applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < MAXC - 1; i++) begin
      nextCycle(); idle();
      midCycle();
      checkOutput("wd wait timeout", int'(mc_timeout), 0);
    end
    nextCycle(); idle();
    midCycle();
    checkOutput("wd pulse", int'(mc_timeout), 1);
    checkOutput("wd busy", int'(mc_busy), 0);
    checkOutput("wd pc_we", int'(pc_we), 1);
    nextCycle(); idle();
    midCycle();
    checkOutput("wd pulse end", int'(mc_timeout), 0);

    $display("[TB] freeze during multi-cycle wait");
    nextCycle(); applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    nextCycle(); idle();
    nextCycle(); idle();
    for (int i = 0; i < 3; i++) begin
      nextCycle(); applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      midCycle();
      checkOutput("frz memwb_we", int'(memwb_we), 0);
      checkOutput("frz exmem_flush", int'(exmem_flush), 0);
      checkOutput("frz busy", int'(mc_busy), 1);
      checkOutput("frz stall_cnt", int'(stall_cnt), PERF * 15);
    end
    for (int i = 0; i < 2; i++) begin
      nextCycle(); idle();
      midCycle();
      checkOutput("frz resume busy", int'(mc_busy), 1);
    end
    nextCycle(); applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    midCycle();
    checkOutput("frz done timeout", int'(mc_timeout), 0);
    checkOutput("frz done exmem_we", int'(exmem_we), 1);
    nextCycle(); idle();
    midCycle();
    checkOutput("frz stall_cnt after", int'(stall_cnt), PERF * 17);

    $display("[TB] reset during multi-cycle wait");
    nextCycle(); applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    nextCycle(); idle();
    nextCycle(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    midCycle();
    checkOutput("rstmid pc_we", int'(pc_we), 0);
    checkOutput("rstmid ifid_flush", int'(ifid_flush), 1);
    checkOutput("rstmid busy", int'(mc_busy), 0);
    nextCycle();
    nextCycle(); idle();
    midCycle();
    checkOutput("rstmid after busy", int'(mc_busy), 0);
    checkOutput("rstmid stall_cnt", int'(stall_cnt), 0);
    checkOutput("rstmid flush_cnt", int'(flush_cnt), 0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 3000; n++) begin
      nextCycle();
      applyStimulus($urandom_range(0, 99) >= 2,
                    $urandom_range(0, 99) < 10,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)),
                    $urandom_range(0, 99) < 40,
                    $urandom_range(0, 99) < 15,
                    $urandom_range(0, 99) < 20,
                    $urandom_range(0, 99) < 20);
    end
    nextCycle(); idle();
    nextCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
